bet_table: RTL and testbench
============================

Name: bet_table

Overview:
Parametrised bet-capture buffer for the roulette design. It takes keyboard bet opcodes and the Arduino chip colour and stores them in NUM_BETS slots, exposing the slots as a flat bus to the regfile. It adds undo, clear, full/reject signalling and a spin lock-out state machine that waits for an explicit spin-complete strobe. It sits between the PS/2 decode path (keyboardToBet) and the regfile.

Parameters:
NUM_BETS, 12, number of bet slots (1..63)
OPC_W, 6, bet opcode width
COLOR_IN_W, 3, raw colour input width; zero means no chip present
COLOR_W, 2, stored colour width, taken from color_in[COLOR_W-1:0]
CLEAR_ON_ROUND, 1, 1 = wipe all slots when a round ends; 0 = keep the slots

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clears all state on the next rising edge of clock
key_valid  in  1  one-cycle strobe: key_opcode is new
key_opcode  in  OPC_W  decoded bet opcode
color_in  in  COLOR_IN_W  Arduino chip colour
spin_done  in  1  one-cycle strobe from processor/regfile: wheel has stopped
bets_flat  out  NUM_BETS*(COLOR_W+OPC_W)  slot i occupies bits [i*BW +: BW], BW=COLOR_W+OPC_W; each slot is {colour, opcode}
bet_count  out  6  number of occupied slots
full  out  1  bet_count == NUM_BETS
spin_active  out  1  high in SPIN state
accept  out  1  one-cycle pulse: last key_valid was taken
reject  out  1  one-cycle pulse: last key_valid was refused
round_done  out  1  one-cycle pulse on leaving SPIN

Behaviour:
- Clock and reset are decided: one clock (clock); reset is synchronous and active-high.
- Reset values: all slots 0, bet_count 0, state OPEN. full, spin_active, accept, reject and round_done are all 0.
- All outputs are registered. accept/reject assert in the cycle after the edge that samples key_valid.
- Opcode classes (decoded only when key_valid=1):
  - NONE = 6'h3F: ignored; neither accept nor reject.
  - SPIN = 6'h3E
  - UNDO = 6'h3D
  - CLEAR = 6'h3C
  - any other value: BET.
- States: OPEN, SPIN, WIPE.
- In OPEN:
  - BET with color_in != 0 and count < NUM_BETS: write {color_in[COLOR_W-1:0], key_opcode} to slot[count]; count+1; accept.
  - BET with color_in == 0, or full: reject; nothing changes.
  - UNDO with count > 0: zero slot[count-1]; count-1; accept. UNDO with count == 0: reject.
  - CLEAR: zero all slots; count 0; accept. This applies even when count is already 0.
  - SPIN with count > 0: go to SPIN; accept. SPIN with count == 0: reject.
  - spin_done in OPEN: ignored.
- In SPIN:
  - Every non-NONE key_valid: reject. Slots are frozen.
  - spin_done: pulse round_done. If CLEAR_ON_ROUND=1 go to WIPE, else go to OPEN.
- WIPE lasts exactly one cycle: zero all slots, count 0, then go to OPEN. A key_valid sampled in WIPE is rejected.
- Simultaneous key_valid and spin_done in SPIN: reject the key and still perform the transition.
- Reset mid-SPIN or mid-WIPE: return to OPEN with the table empty. No round_done pulse.
- Slots at index >= count always read 0.
- bets_flat is stable except on the edge following an accepted operation or a WIPE.
- bet_count never exceeds NUM_BETS and never underflows.

Decomposition:
- Shared package bet_pkg holds:
  - opcode constants OPC_NONE, OPC_SPIN, OPC_UNDO, OPC_CLEAR
  - state enum OPEN/SPIN/WIPE
  - a slot-width function BW
- One natural sub-module: bet_key_classifier. It is combinational and maps {key_valid, key_opcode, color_in, count, state} to an action: NOP/WRITE/UNDO/CLEAR/SPIN/REJECT.
- The top level holds the slot array, the counter and the FSM.

Test Plan:
- Reset, then three BETs: opcodes 5, 9, 17 with color_in=3'b010 -> slots 0..2 = 8'h85, 8'h89, 8'h91; bet_count 3; three accept pulses.
- BET with color_in=0 -> reject; bet_count unchanged.
- Fill to 12, then a 13th BET -> full=1, reject; slot 11 holds the 12th bet.
- UNDO after 3 bets -> slot 2 = 0, count 2. Two more UNDOs take count to 0; a further UNDO -> reject, count stays 0.
- SPIN with count=2 -> spin_active=1. A BET during SPIN is rejected and the slots are unchanged. Then spin_done with CLEAR_ON_ROUND=1 -> round_done pulse, then all slots 0, count 0, spin_active=0, OPEN. With CLEAR_ON_ROUND=0 the slots are retained.
- SPIN with count=0 -> reject, stays OPEN. Reset asserted in SPIN -> next cycle OPEN, count 0, no round_done.

Source files
------------

// File: rtl/bet_pkg.sv
// Shared constants, state/action enums and slot-width helper for the bet-capture buffer.
package bet_pkg;

    localparam int unsigned CNT_W = 6;

    localparam logic [5:0] OPC_NONE  = 6'h3F;
    localparam logic [5:0] OPC_SPIN  = 6'h3E;
    localparam logic [5:0] OPC_UNDO  = 6'h3D;
    localparam logic [5:0] OPC_CLEAR = 6'h3C;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_SPIN,
        ST_WIPE
    } state_t;

    typedef enum logic [2:0] {
        ACT_NOP,
        ACT_WRITE,
        ACT_UNDO,
        ACT_CLEAR,
        ACT_SPIN,
        ACT_REJECT
    } action_t;

    function automatic int unsigned BW(input int unsigned color_w, input int unsigned opc_w);
        return color_w + opc_w;
    endfunction

endpackage

// File: rtl/bet_key_classifier.sv
// Combinational decode of a key strobe into the table action for the current state.
module bet_key_classifier
    import bet_pkg::*;
#(
    parameter int unsigned NUM_BETS   = 12,
    parameter int unsigned OPC_W      = 6,
    parameter int unsigned COLOR_IN_W = 3
) (
    input  logic                  key_valid,
    input  logic [OPC_W-1:0]      key_opcode,
    input  logic [COLOR_IN_W-1:0] color_in,
    input  logic [CNT_W-1:0]      count,
    input  state_t                state,
    output action_t               action_c
);

    logic has_bets;
    logic has_room;

    assign has_bets = (count != '0);
    assign has_room = (count < CNT_W'(NUM_BETS));

    always_comb begin
        action_c = ACT_NOP;
        if (key_valid && (key_opcode != OPC_W'(OPC_NONE))) begin
            if (state != ST_OPEN) begin
                action_c = ACT_REJECT;
            end else if (key_opcode == OPC_W'(OPC_SPIN)) begin
                action_c = has_bets ? ACT_SPIN : ACT_REJECT;
            end else if (key_opcode == OPC_W'(OPC_UNDO)) begin
                action_c = has_bets ? ACT_UNDO : ACT_REJECT;
            end else if (key_opcode == OPC_W'(OPC_CLEAR)) begin
                action_c = ACT_CLEAR;
            end else begin
                action_c = ((color_in != '0) && has_room) ? ACT_WRITE : ACT_REJECT;
            end
        end
    end

endmodule

// File: rtl/bet_table.sv
// Bet-capture buffer: slot array, occupancy counter and OPEN/SPIN/WIPE lock-out FSM.
module bet_table
    import bet_pkg::*;
#(
    parameter int unsigned NUM_BETS       = 12,
    parameter int unsigned OPC_W          = 6,
    parameter int unsigned COLOR_IN_W     = 3,
    parameter int unsigned COLOR_W        = 2,
    parameter int unsigned CLEAR_ON_ROUND = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  key_valid,
    input  logic [OPC_W-1:0]                      key_opcode,
    input  logic [COLOR_IN_W-1:0]                 color_in,
    input  logic                                  spin_done,
    output logic [NUM_BETS*BW(COLOR_W, OPC_W)-1:0] bets_flat,
    output logic [CNT_W-1:0]                      bet_count,
    output logic                                  full,
    output logic                                  spin_active,
    output logic                                  accept,
    output logic                                  reject,
    output logic                                  round_done
);

    localparam int unsigned SLOT_W = BW(COLOR_W, OPC_W);

    state_t              state, state_next;
    action_t             action_c;
    logic [CNT_W-1:0]    count, count_next;
    logic [SLOT_W-1:0]   slots [NUM_BETS];
    logic [SLOT_W-1:0]   wdata;
    logic                do_write, do_undo, do_clear;
    logic                accept_next, reject_next, round_done_next;

    bet_key_classifier #(
        .NUM_BETS   (NUM_BETS),
        .OPC_W      (OPC_W),
        .COLOR_IN_W (COLOR_IN_W)
    ) u_classifier (
        .key_valid  (key_valid),
        .key_opcode (key_opcode),
        .color_in   (color_in),
        .count      (count),
        .state      (state),
        .action_c   (action_c)
    );

    assign wdata = {color_in[COLOR_W-1:0], key_opcode};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        do_write        = 1'b0;
        do_undo         = 1'b0;
        do_clear        = 1'b0;
        accept_next     = 1'b0;
        reject_next     = (action_c == ACT_REJECT);
        round_done_next = 1'b0;
        case (state)
            ST_OPEN: begin
                case (action_c)
                    ACT_WRITE: begin
                        do_write    = 1'b1;
                        count_next  = count + CNT_W'(1);
                        accept_next = 1'b1;
                    end
                    ACT_UNDO: begin
                        do_undo     = 1'b1;
                        count_next  = count - CNT_W'(1);
                        accept_next = 1'b1;
                    end
                    ACT_CLEAR: begin
                        do_clear    = 1'b1;
                        count_next  = '0;
                        accept_next = 1'b1;
                    end
                    ACT_SPIN: begin
                        state_next  = ST_SPIN;
                        accept_next = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_SPIN: begin
                // A key arriving with spin_done is already rejected by the classifier.
                if (spin_done) begin
                    round_done_next = 1'b1;
                    state_next      = (CLEAR_ON_ROUND != 0) ? ST_WIPE : ST_OPEN;
                end
            end
            ST_WIPE: begin
                do_clear   = 1'b1;
                count_next = '0;
                state_next = ST_OPEN;
            end
            default: state_next = ST_OPEN;
        endcase
    end

    // Counter and registered status/pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            full        <= 1'b0;
            spin_active <= 1'b0;
            accept      <= 1'b0;
            reject      <= 1'b0;
            round_done  <= 1'b0;
        end else begin
            count       <= count_next;
            full        <= (count_next == CNT_W'(NUM_BETS));
            spin_active <= (state_next == ST_SPIN);
            accept      <= accept_next;
            reject      <= reject_next;
            round_done  <= round_done_next;
        end
    end

    // Slot storage: writes land at count, undo clears count-1, so slots above count stay zero.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_BETS); i++) begin
            if (reset || do_clear) begin
                slots[i] <= '0;
            end else if (do_write && (count == CNT_W'(i))) begin
                slots[i] <= wdata;
            end else if (do_undo && (count == CNT_W'(i + 1))) begin
                slots[i] <= '0;
            end
        end
    end

    assign bet_count = count;

    for (genvar g = 0; g < int'(NUM_BETS); g++) begin : g_flat
        assign bets_flat[g*SLOT_W +: SLOT_W] = slots[g];
    end

endmodule

// File: tb/tb_bet_table.sv
// Randomised scoreboard bench for bet_table, with wiping and retaining instances side by side.
module tb_bet_table;

    localparam int NB = 12;
    localparam int FW = NB * 8;

    typedef struct {
        logic [FW-1:0] flat;
        int            cnt;
        bit            full;
        bit            spin;
        bit            acc;
        bit            rej;
        bit            rd;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          key_valid = 1'b0;
    logic [5:0]    key_opcode = 6'h3F;
    logic [2:0]    color_in = 3'd0;
    logic          spin_done = 1'b0;

    logic [FW-1:0] a_flat, b_flat;
    logic [5:0]    a_count, b_count;
    logic          a_full, a_spin, a_acc, a_rej, a_rd;
    logic          b_full, b_spin, b_acc, b_rej, b_rd;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [7:0] m_slots [2][NB];
    int         m_cnt   [2];
    int         m_phase [2];   // 0 open, 1 spinning, 2 wiping

    always #5 clock = ~clock;

    bet_table #(.CLEAR_ON_ROUND(1)) u_wipe (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_opcode(key_opcode),
        .color_in(color_in), .spin_done(spin_done), .bets_flat(a_flat), .bet_count(a_count),
        .full(a_full), .spin_active(a_spin), .accept(a_acc), .reject(a_rej), .round_done(a_rd)
    );

    bet_table #(.CLEAR_ON_ROUND(0)) u_keep (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_opcode(key_opcode),
        .color_in(color_in), .spin_done(spin_done), .bets_flat(b_flat), .bet_count(b_count),
        .full(b_full), .spin_active(b_spin), .accept(b_acc), .reject(b_rej), .round_done(b_rd)
    );

    // Reference model: a list of bets with a length, plus a round phase.
    function automatic exp_t step(int k, bit clr_round, bit rst, bit kv, logic [5:0] op,
                                  logic [2:0] col, bit sd);
        exp_t e;
        bit   key;
        e.acc = 0; e.rej = 0; e.rd = 0;
        key = kv && (op != 6'h3F);
        if (rst) begin
            for (int i = 0; i < NB; i++) m_slots[k][i] = 8'h00;
            m_cnt[k] = 0;
            m_phase[k] = 0;
        end else if (m_phase[k] == 2) begin
            for (int i = 0; i < NB; i++) m_slots[k][i] = 8'h00;
            m_cnt[k] = 0;
            m_phase[k] = 0;
            e.rej = key;
        end else if (m_phase[k] == 1) begin
            e.rej = key;
            if (sd) begin
                e.rd = 1;
                m_phase[k] = clr_round ? 2 : 0;
            end
        end else if (key) begin
            if (op == 6'h3E) begin
                if (m_cnt[k] > 0) begin m_phase[k] = 1; e.acc = 1; end
                else e.rej = 1;
            end else if (op == 6'h3D) begin
                if (m_cnt[k] > 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    m_slots[k][m_cnt[k]] = 8'h00;
                    e.acc = 1;
                end else e.rej = 1;
            end else if (op == 6'h3C) begin
                for (int i = 0; i < NB; i++) m_slots[k][i] = 8'h00;
                m_cnt[k] = 0;
                e.acc = 1;
            end else if (col != 3'd0 && m_cnt[k] < NB) begin
                m_slots[k][m_cnt[k]] = {col[1:0], op};
                m_cnt[k] = m_cnt[k] + 1;
                e.acc = 1;
            end else begin
                e.rej = 1;
            end
        end
        for (int i = 0; i < NB; i++) e.flat[i*8 +: 8] = m_slots[k][i];
        e.cnt  = m_cnt[k];
        e.full = (m_cnt[k] == NB);
        e.spin = (m_phase[k] == 1);
        return e;
    endfunction

    task automatic check(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle; the expectation is queued once the edge has sampled the inputs.
    task automatic drive(bit rst, bit kv, logic [5:0] op, logic [2:0] col, bit sd);
        reset = rst; key_valid = kv; key_opcode = op; color_in = col; spin_done = sd;
        @(posedge clock);
        q_a.push_back(step(0, 1'b1, rst, kv, op, col, sd));
        q_b.push_back(step(1, 1'b0, rst, kv, op, col, sd));
        #1;
        reset = 0; key_valid = 0; key_opcode = 6'h3F; color_in = 3'd0; spin_done = 0;
    endtask

    task automatic key(logic [5:0] op, logic [2:0] col);
        drive(1'b0, 1'b1, op, col, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'h3F, 3'd0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clock) begin
        exp_t ea, eb;
        if (q_a.size() > 0 && q_b.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("wipe.bets_flat",   FW'(a_flat),  ea.flat);
            check("wipe.bet_count",   FW'(a_count), FW'(ea.cnt));
            check("wipe.full",        FW'(a_full),  FW'(ea.full));
            check("wipe.spin_active", FW'(a_spin),  FW'(ea.spin));
            check("wipe.accept",      FW'(a_acc),   FW'(ea.acc));
            check("wipe.reject",      FW'(a_rej),   FW'(ea.rej));
            check("wipe.round_done",  FW'(a_rd),    FW'(ea.rd));
            check("keep.bets_flat",   FW'(b_flat),  eb.flat);
            check("keep.bet_count",   FW'(b_count), FW'(eb.cnt));
            check("keep.full",        FW'(b_full),  FW'(eb.full));
            check("keep.spin_active", FW'(b_spin),  FW'(eb.spin));
            check("keep.accept",      FW'(b_acc),   FW'(eb.acc));
            check("keep.reject",      FW'(b_rej),   FW'(eb.rej));
            check("keep.round_done",  FW'(b_rd),    FW'(eb.rd));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int         r;

        drive(1'b1, 1'b0, 6'h3F, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 6'h3F, 3'd0, 1'b0);
        idle();

        // Three bets, a colourless bet, undo down to empty and past it.
        key(6'd5, 3'b010); key(6'd9, 3'b010); key(6'd17, 3'b010);
        key(6'd20, 3'b000);
        key(6'h3F, 3'b001);
        key(6'h3D, 3'd0); key(6'h3D, 3'd0); key(6'h3D, 3'd0); key(6'h3D, 3'd0);

        // Fill to capacity and overflow, then clear.
        for (int i = 0; i < NB + 1; i++) key(6'(i + 1), 3'(1 + (i % 7)));
        key(6'h3C, 3'd0);
        key(6'h3C, 3'd0);

        // Spin lock-out and round end.
        key(6'h3E, 3'd0);
        key(6'd7, 3'b011); key(6'd8, 3'b101);
        drive(1'b0, 1'b0, 6'h3F, 3'd0, 1'b1);
        key(6'h3E, 3'd0);
        key(6'd9, 3'b001);
        key(6'h3D, 3'd0);
        drive(1'b0, 1'b1, 6'd10, 3'b010, 1'b1);
        key(6'd11, 3'b010);
        idle(); idle();

        // Reset in the middle of a spin; key colliding with spin_done.
        key(6'h3E, 3'd0);
        drive(1'b1, 1'b0, 6'h3F, 3'd0, 1'b0);
        idle();
        key(6'd12, 3'b110); key(6'h3E, 3'd0);
        drive(1'b0, 1'b1, 6'd13, 3'b001, 1'b1);
        drive(1'b0, 1'b1, 6'h3C, 3'd0, 1'b0);
        idle(); idle();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1:    op = 6'h3F;
                2, 3:    op = 6'h3E;
                4, 5:    op = 6'h3D;
                6:       op = 6'h3C;
                default: op = 6'($urandom_range(0, 59));
            endcase
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, op,
                  3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
        end

        idle();
        @(posedge clock);
        @(posedge clock);
        check("queue_drain", FW'(q_a.size()), FW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
